// File: rtl/wb_cmd_sequencer_if.sv
// ============================================================================
// Module      : wb_cmd_sequencer_if
// Description : Command, response and controller local-port signals of the
//               wishbone command sequencer, with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_cmd_sequencer_if;
    // command queue input
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] cmd_cmp;
    // response output
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    // status
    logic       busy;
    logic       op_err;
    // wishbone_controller local port
    logic [7:0] address;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       xfer_done;

    // Sequencer view.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_cmp,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_timeout,
        input  rsp_ready,
        output busy, op_err,
        output address, wr_en, wr_data, rd_en,
        input  rd_data, xfer_done
    );

    // Command source / controller side view.
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_cmp,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_timeout,
        output rsp_ready,
        input  busy, op_err,
        input  address, wr_en, wr_data, rd_en,
        output rd_data, xfer_done
    );
endinterface

`default_nettype wire

// File: rtl/wb_cmd_sequencer.sv
// ============================================================================
// Module      : wb_cmd_sequencer
// Description : Queued write/read/poll command front end for the EFB
//               wishbone_controller local port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_cmd_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int POLL_MAX  = 255,
    parameter int POLL_GAP  = 8
) (
    input  wire logic           wb_clk_i,
    input  wire logic           wb_rst_n_i,
    wb_cmd_sequencer_if.slave   bus
);

    localparam int              c_ptr_w    = $clog2(CMD_DEPTH);
    localparam int              c_gap_w    = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(POLL_GAP - 1);
    localparam logic [7:0]      c_poll_max = 8'(POLL_MAX);
    localparam logic [1:0]      c_op_wr    = 2'b00;
    localparam logic [1:0]      c_op_rd    = 2'b01;
    localparam logic [1:0]      c_op_poll  = 2'b10;
    localparam logic [1:0]      c_op_rsvd  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_GAP   = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit for full/empty.
    // ------------------------------------------------------------------
    logic [25:0]        r_mem [CMD_DEPTH];
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_head_op;
    logic [7:0]         w_head_addr;
    logic [7:0]         w_head_data;
    logic [7:0]         w_head_cmp;

    // Latched command and sequencing state
    logic [1:0]         r_op;
    logic [7:0]         r_address;
    logic [7:0]         r_data;
    logic [7:0]         r_cmp;
    logic [7:0]         r_attempts;
    logic [c_gap_w-1:0] r_gap;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_data;
    logic               r_rsp_timeout;
    logic               r_op_err;

    logic [7:0]         w_att_next;
    logic               w_match;
    logic               w_ack;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_push  = bus.cmd_valid && !w_full;
    // A held response blocks the queue so results leave in command order.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !r_rsp_valid;

    assign {w_head_op, w_head_addr, w_head_data, w_head_cmp} = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    assign w_ack      = (r_state == S_WAIT) && bus.xfer_done;
    assign w_att_next = r_attempts + 8'd1;
    assign w_match    = ((bus.rd_data & r_data) == r_cmp);

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {bus.cmd_op, bus.cmd_addr, bus.cmd_data, bus.cmd_cmp};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop && (w_head_op != c_op_rsvd)) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.xfer_done) begin
                    if (r_op == c_op_wr) begin
                        w_next_state = S_IDLE;
                    end else if ((r_op == c_op_rd) || w_match || (w_att_next == c_poll_max)) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_op          <= c_op_wr;
            r_address     <= 8'd0;
            r_data        <= 8'd0;
            r_cmp         <= 8'd0;
            r_attempts    <= 8'd0;
            r_gap         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'd0;
            r_rsp_timeout <= 1'b0;
            r_op_err      <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_head_op == c_op_rsvd) begin
                    r_op_err <= 1'b1;
                end else begin
                    r_op       <= w_head_op;
                    r_address  <= w_head_addr;
                    r_data     <= w_head_data;
                    r_cmp      <= w_head_cmp;
                    r_attempts <= 8'd0;
                end
            end

            if (w_ack && (r_op != c_op_wr)) begin
                r_rsp_data    <= bus.rd_data;
                r_attempts    <= w_att_next;
                r_rsp_timeout <= (r_op == c_op_poll) && !w_match && (w_att_next == c_poll_max);
            end

            if (r_state == S_GAP) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end

            // Valid rises the cycle after entering RESP and drops on handshake.
            if (r_state == S_RESP) begin
                if (!r_rsp_valid) begin
                    r_rsp_valid <= 1'b1;
                end else if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cmd_ready   = !w_full;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.busy        = !w_empty || (r_state != S_IDLE);
    assign bus.op_err      = r_op_err;
    assign bus.address     = r_address;
    assign bus.wr_data     = r_data;
    assign bus.wr_en       = (r_state == S_ISSUE) && (r_op == c_op_wr);
    assign bus.rd_en       = (r_state == S_ISSUE) && (r_op != c_op_wr);

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_sequencer.sv
// ============================================================================
// Module      : tb_wb_cmd_sequencer
// Description : Directed bench for wb_cmd_sequencer with an acking slave model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_cmd_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_cmd_sequencer_if bus ();

    wb_cmd_sequencer #(
        .CMD_DEPTH (4),
        .POLL_MAX  (4),
        .POLL_GAP  (8)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: acks each pulse ack_delay cycles later, read data from ret_mem.
    int         ack_delay = 1;
    logic [7:0] ret_mem [64];
    int         ret_idx   = 0;
    int         n_wr      = 0;
    int         n_rd      = 0;
    int         ack_cyc   = 0;
    int         rd_cyc [64];
    logic       pending   = 1'b0;
    logic       pend_rd   = 1'b0;
    int         cnt       = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending       = 1'b0;
            cnt           = 0;
            bus.xfer_done = 1'b0;
            bus.rd_data   = 8'd0;
        end else begin
            bus.xfer_done = 1'b0;
            if (pending) begin
                if (cnt <= 1) begin
                    bus.xfer_done = 1'b1;
                    ack_cyc       = cyc;
                    pending       = 1'b0;
                    if (pend_rd) begin
                        bus.rd_data = ret_mem[ret_idx & 63];
                        ret_idx++;
                    end
                end else begin
                    cnt--;
                end
            end
            if (bus.wr_en || bus.rd_en) begin
                pending = 1'b1;
                cnt     = ack_delay;
                pend_rd = bus.rd_en;
                if (bus.rd_en) begin
                    rd_cyc[n_rd & 63] = cyc;
                    n_rd++;
                end else begin
                    n_wr++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_cmp   = c;
        for (int i = 0; i < 200 && !bus.cmd_ready; i++) tick();
        if (!bus.cmd_ready) check("push_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 400 && !bus.rsp_valid; i++) tick();
        check(tag, bus.rsp_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400 && bus.busy; i++) tick();
        check(tag, bus.busy, 0);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        int t0;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'd0;
        bus.cmd_data  = 8'd0;
        bus.cmd_cmp   = 8'd0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_cmd_ready",   bus.cmd_ready,   1);
        check("rst_rsp_valid",   bus.rsp_valid,   0);
        check("rst_rsp_data",    bus.rsp_data,    0);
        check("rst_rsp_timeout", bus.rsp_timeout, 0);
        check("rst_busy",        bus.busy,        0);
        check("rst_op_err",      bus.op_err,      0);
        check("rst_address",     bus.address,     0);
        check("rst_wr_en",       bus.wr_en,       0);
        check("rst_wr_data",     bus.wr_data,     0);
        check("rst_rd_en",       bus.rd_en,       0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Write 0x5A to 0x40, ack 2 cycles after the pulse
        ack_delay = 2;
        w0 = n_wr;
        push(2'b00, 8'h40, 8'h5A, 8'h00);
        tick();
        check("wr_pulse",    bus.wr_en,   1);
        check("wr_address",  bus.address, 8'h40);
        check("wr_data",     bus.wr_data, 8'h5A);
        tick();
        check("wr_pulse_end", bus.wr_en,  0);
        wait_idle("wr_idle");
        check("wr_busy_drop", cyc, ack_cyc + 1);
        check("wr_count",     n_wr - w0, 1);
        check("wr_no_rsp",    bus.rsp_valid, 0);

        // Read 0x41 -> 0xC3, ack one cycle after the pulse
        ack_delay = 1;
        ret_mem[ret_idx & 63] = 8'hC3;
        r0 = n_rd;
        push(2'b01, 8'h41, 8'h00, 8'h00);
        tick();
        check("rd_pulse",   bus.rd_en,   1);
        check("rd_address", bus.address, 8'h41);
        wait_rsp("rd_rsp");
        check("rd_latency", cyc, ack_cyc + 2);
        check("rd_data",    bus.rsp_data, 8'hC3);
        check("rd_timeout", bus.rsp_timeout, 0);
        check("rd_count",   n_rd - r0, 1);
        consume();
        check("rd_consumed", bus.rsp_valid, 0);

        // Poll 0x42 mask 0x80 cmp 0x00, slave returns 0x80, 0x80, 0x00
        ret_mem[(ret_idx + 0) & 63] = 8'h80;
        ret_mem[(ret_idx + 1) & 63] = 8'h80;
        ret_mem[(ret_idx + 2) & 63] = 8'h00;
        r0 = n_rd;
        push(2'b10, 8'h42, 8'h80, 8'h00);
        wait_rsp("poll_rsp");
        check("poll_count",   n_rd - r0, 3);
        check("poll_gap_1",   (rd_cyc[(r0 + 1) & 63] - rd_cyc[r0 & 63]) >= 10, 1);
        check("poll_gap_2",   (rd_cyc[(r0 + 2) & 63] - rd_cyc[(r0 + 1) & 63]) >= 10, 1);
        check("poll_data",    bus.rsp_data, 8'h00);
        check("poll_timeout", bus.rsp_timeout, 0);
        consume();

        // Poll that never matches: POLL_MAX=4 reads then timeout
        ret_mem[(ret_idx + 0) & 63] = 8'h11;
        ret_mem[(ret_idx + 1) & 63] = 8'h22;
        ret_mem[(ret_idx + 2) & 63] = 8'h33;
        ret_mem[(ret_idx + 3) & 63] = 8'h44;
        r0 = n_rd;
        push(2'b10, 8'h43, 8'hFF, 8'h00);
        wait_rsp("pto_rsp");
        check("pto_count",   n_rd - r0, 4);
        check("pto_timeout", bus.rsp_timeout, 1);
        check("pto_data",    bus.rsp_data, 8'h44);
        consume();
        repeat (30) tick();
        check("pto_no_extra", n_rd - r0, 4);

        // Held response stalls the queue; four pushes fill the FIFO
        ret_mem[ret_idx & 63] = 8'hA1;
        push(2'b01, 8'h50, 8'h00, 8'h00);
        wait_rsp("fifo_rsp1");
        ret_mem[(ret_idx + 0) & 63] = 8'hA2;
        ret_mem[(ret_idx + 1) & 63] = 8'hA3;
        w0 = n_wr;
        r0 = n_rd;
        push(2'b00, 8'h51, 8'h77, 8'h00);
        push(2'b01, 8'h52, 8'h00, 8'h00);
        push(2'b01, 8'h53, 8'h00, 8'h00);
        push(2'b00, 8'h54, 8'h88, 8'h00);
        check("fifo_full",     bus.cmd_ready, 0);
        check("fifo_busy",     bus.busy, 1);
        check("fifo_stall_rd", n_rd - r0, 0);
        check("fifo_stall_wr", n_wr - w0, 0);
        check("fifo_rsp1_data", bus.rsp_data, 8'hA1);
        check("fifo_rsp1_addr", bus.address, 8'h50);
        consume();
        wait_rsp("fifo_rsp2");
        check("fifo_rsp2_data", bus.rsp_data, 8'hA2);
        check("fifo_rsp2_addr", bus.address, 8'h52);
        check("fifo_rsp2_to",   bus.rsp_timeout, 0);
        consume();
        wait_rsp("fifo_rsp3");
        check("fifo_rsp3_data", bus.rsp_data, 8'hA3);
        check("fifo_rsp3_addr", bus.address, 8'h53);
        consume();
        wait_idle("fifo_idle");
        check("fifo_wr_count", n_wr - w0, 2);
        check("fifo_last_addr", bus.address, 8'h54);
        check("fifo_last_data", bus.wr_data, 8'h88);
        check("fifo_ready",     bus.cmd_ready, 1);

        // Reserved op between two writes
        check("operr_before", bus.op_err, 0);
        w0 = n_wr;
        r0 = n_rd;
        push(2'b00, 8'h60, 8'h01, 8'h00);
        push(2'b11, 8'h61, 8'h00, 8'h00);
        push(2'b00, 8'h62, 8'h02, 8'h00);
        wait_idle("operr_idle");
        check("operr_set",     bus.op_err, 1);
        check("operr_wr",      n_wr - w0, 2);
        check("operr_rd",      n_rd - r0, 0);
        check("operr_addr",    bus.address, 8'h62);
        check("operr_wdata",   bus.wr_data, 8'h02);
        check("operr_no_rsp",  bus.rsp_valid, 0);

        // Asynchronous reset while a poll waits for its ack
        ack_delay = 40;
        ret_mem[ret_idx & 63] = 8'h00;
        r0 = n_rd;
        t0 = ret_idx;
        push(2'b10, 8'h70, 8'h01, 8'h01);
        tick();
        check("arst_pulse", bus.rd_en, 1);
        repeat (2) tick();
        check("arst_busy_pre", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",      bus.busy, 0);
        check("arst_address",   bus.address, 0);
        check("arst_wr_data",   bus.wr_data, 0);
        check("arst_op_err",    bus.op_err, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_rsp_data",  bus.rsp_data, 0);
        check("arst_cmd_ready", bus.cmd_ready, 1);
        check("arst_rd_en",     bus.rd_en, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        check("arst_no_rsp",   bus.rsp_valid, 0);
        check("arst_no_pulse", n_rd - r0, 1);
        check("arst_no_ack",   ret_idx - t0, 0);
        check("arst_idle",     bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
